// File: rtl/compositor_pkg.sv
// compositor_pkg: colour types and constants shared by the layer compositor.
package compositor_pkg;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  localparam rgb_t [3:0] TANK_COLOR = {24'h8000FF, 24'h00C000, 24'hFF0000, 24'hFFBB00};
  localparam rgb_t HEAD_COLOR = 24'h00FFFF;
  localparam rgb_t BG_COLOR = 24'h555555;
  localparam rgb_t OUTLINE_COLOR = 24'h000000;
  localparam rgb_t WHITE = 24'hFFFFFF;
  localparam rgb_t BLACK = 24'h000000;
  localparam int TRIG_FRAC_OFS = 2;
endpackage

// File: rtl/tank_rotator.sv
// tank_rotator: rotates the pixel into one tank's local frame and tests head/body (two stages).
// With TANK_OUTLINE_EN defined it also flags body pixels on the square's rim.
module tank_rotator
  import compositor_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int TRIG_W = 8,
  parameter int HEAD_HALF = 6
) (
  input  logic                     CLK,
  input  logic                     Reset_n,
  input  logic [COORD_W-1:0]       DrawX,
  input  logic [COORD_W-1:0]       DrawY,
  input  logic [COORD_W-1:0]       tx,
  input  logic [COORD_W-1:0]       ty,
  input  logic [COORD_W-1:0]       size,
  input  logic signed [TRIG_W-1:0] sin_h,
  input  logic signed [TRIG_W-1:0] cos_h,
  input  logic                     dead,
  output logic                     head,
  output logic                     body,
  output logic                     rim
);
  localparam int DW = COORD_W + 1;
  localparam int PW = DW + TRIG_W;
  localparam int SW = PW + 1;
  localparam int F = TRIG_W - TRIG_FRAC_OFS;
  localparam logic signed [SW-1:0] HH = SW'(HEAD_HALF);
  logic signed [DW-1:0] dx, dy;
  logic signed [PW-1:0] xc, ys, xs, yc;
  logic signed [SW-1:0] sx, sy, lx, ly, ax, ay, sz;
  logic head_c, body_c;
  assign dx = $signed({1'b0, DrawX}) - $signed({1'b0, tx});
  assign dy = $signed({1'b0, DrawY}) - $signed({1'b0, ty});
  // full-width sums so the shift back to pixels never wraps
  assign sx = xc + ys;
  assign sy = yc - xs;
  assign lx = sx >>> F;
  assign ly = sy >>> F;
  assign ax = lx[SW-1] ? -lx : lx;
  assign ay = ly[SW-1] ? -ly : ly;
  assign sz = $signed({{(SW-COORD_W){1'b0}}, size});
  assign head_c = !dead && !lx[SW-1] && lx <= sz && ay <= HH;
  assign body_c = !dead && ax <= sz && ay <= sz;
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      xc <= '0;
      ys <= '0;
      xs <= '0;
      yc <= '0;
      head <= 1'b0;
      body <= 1'b0;
    end else begin
      xc <= dx * cos_h;
      ys <= dy * sin_h;
      xs <= dx * sin_h;
      yc <= dy * cos_h;
      head <= head_c;
      body <= body_c;
    end
`ifdef TANK_OUTLINE_EN
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) rim <= 1'b0;
    else rim <= body_c && (ax == sz || ay == sz);
`else
  assign rim = 1'b0;
`endif
endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: 3-stage tank/bullet/maze/title compositor with per-frame shadows and hit reporting.
// Define TANK_OUTLINE_EN to draw tank bodies with a black outline.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_TANKS = 2,
  parameter int NUM_BULLETS = 3,
  parameter int COORD_W = 10,
  parameter int TRIG_W = 8,
  parameter int HEAD_HALF = 6
) (
  input  logic                             CLK,
  input  logic                             Reset_n,
  input  logic                             frame_start,
  input  logic [COORD_W-1:0]               DrawX,
  input  logic [COORD_W-1:0]               DrawY,
  input  logic                             blank,
  input  logic                             maze,
  input  logic                             title,
  input  logic [NUM_TANKS*COORD_W-1:0]     tank_x,
  input  logic [NUM_TANKS*COORD_W-1:0]     tank_y,
  input  logic [COORD_W-1:0]               tank_size,
  input  logic [NUM_TANKS*TRIG_W-1:0]      tank_sin,
  input  logic [NUM_TANKS*TRIG_W-1:0]      tank_cos,
  input  logic [NUM_TANKS-1:0]             tank_dead,
  input  logic [NUM_BULLETS*COORD_W-1:0]   bul_x,
  input  logic [NUM_BULLETS*COORD_W-1:0]   bul_y,
  input  logic [NUM_BULLETS*COORD_W-1:0]   bul_s,
  input  logic [NUM_BULLETS-1:0]           bul_active,
  output logic [7:0]                       Red,
  output logic [7:0]                       Green,
  output logic [7:0]                       Blue,
  output logic [NUM_TANKS*NUM_BULLETS-1:0] hit_flags,
  output logic                             hit_valid
);
  localparam int DW = COORD_W + 1;
  logic [NUM_TANKS*COORD_W-1:0] s_tx, s_ty;
  logic [COORD_W-1:0] s_tsz;
  logic [NUM_TANKS*TRIG_W-1:0] s_sin, s_cos;
  logic [NUM_TANKS-1:0] s_dead;
  logic [NUM_BULLETS*COORD_W-1:0] s_bx, s_by, s_bs;
  logic [NUM_BULLETS-1:0] s_ba;
  logic latched;
  logic [COORD_W-1:0] x1, y1;
  logic blank1, maze1, title1, blank2, maze2, title2;
  logic [NUM_TANKS-1:0] head2, body2, rim2;
  logic [NUM_BULLETS-1:0] bul_c, bul2;
  logic [NUM_TANKS*NUM_BULLETS-1:0] acc, acc_set;
  rgb_t chain [NUM_TANKS+1];
  rgb_t col, rgb_q;
  // latched keeps all-zero shadows from drawing a tank over the whole screen before the first frame
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      s_tx <= '0;
      s_ty <= '0;
      s_tsz <= '0;
      s_sin <= '0;
      s_cos <= '0;
      s_dead <= '0;
      s_bx <= '0;
      s_by <= '0;
      s_bs <= '0;
      s_ba <= '0;
      latched <= 1'b0;
    end else if (frame_start) begin
      s_tx <= tank_x;
      s_ty <= tank_y;
      s_tsz <= tank_size;
      s_sin <= tank_sin;
      s_cos <= tank_cos;
      s_dead <= tank_dead;
      s_bx <= bul_x;
      s_by <= bul_y;
      s_bs <= bul_s;
      s_ba <= bul_active;
      latched <= 1'b1;
    end
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      x1 <= '0;
      y1 <= '0;
      {blank1, maze1, title1, blank2, maze2, title2} <= '0;
      bul2 <= '0;
      rgb_q <= BLACK;
    end else begin
      x1 <= DrawX;
      y1 <= DrawY;
      {blank1, maze1, title1} <= {blank, maze, title};
      {blank2, maze2, title2} <= {blank1, maze1, title1};
      bul2 <= bul_c;
      rgb_q <= col;
    end
  genvar t, b;
  for (t = 0; t < NUM_TANKS; t++) begin : g_tank
    tank_rotator #(.COORD_W(COORD_W), .TRIG_W(TRIG_W), .HEAD_HALF(HEAD_HALF)) u_rot (
      .CLK(CLK),
      .Reset_n(Reset_n),
      .DrawX(DrawX),
      .DrawY(DrawY),
      .tx(s_tx[t*COORD_W +: COORD_W]),
      .ty(s_ty[t*COORD_W +: COORD_W]),
      .size(s_tsz),
      .sin_h(s_sin[t*TRIG_W +: TRIG_W]),
      .cos_h(s_cos[t*TRIG_W +: TRIG_W]),
      .dead(s_dead[t] | !latched),
      .head(head2[t]),
      .body(body2[t]),
      .rim(rim2[t])
    );
    assign chain[t] = head2[t] ? HEAD_COLOR :
                      !body2[t] ? chain[t+1] :
                      rim2[t] ? OUTLINE_COLOR : TANK_COLOR[t];
    for (b = 0; b < NUM_BULLETS; b++) begin : g_acc
      assign acc_set[t*NUM_BULLETS+b] = blank2 & body2[t] & bul2[b];
    end
  end
  assign chain[NUM_TANKS] = BG_COLOR;
  for (b = 0; b < NUM_BULLETS; b++) begin : g_bul
    logic signed [DW-1:0] dx, dy, ax, ay, bs;
    assign dx = $signed({1'b0, x1}) - $signed({1'b0, s_bx[b*COORD_W +: COORD_W]});
    assign dy = $signed({1'b0, y1}) - $signed({1'b0, s_by[b*COORD_W +: COORD_W]});
    assign ax = dx[DW-1] ? -dx : dx;
    assign ay = dy[DW-1] ? -dy : dy;
    assign bs = $signed({1'b0, s_bs[b*COORD_W +: COORD_W]});
    assign bul_c[b] = s_ba[b] && ax <= bs && ay <= bs;
  end
  assign col = !blank2 ? BLACK :
               title2 ? WHITE :
               maze2 ? BLACK :
               |bul2 ? BLACK : chain[0];
  // a hit landing on the clear cycle is dropped; frame_start only occurs in blanking
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      acc <= '0;
      hit_flags <= '0;
      hit_valid <= 1'b0;
    end else if (frame_start) begin
      hit_flags <= acc;
      acc <= '0;
      hit_valid <= 1'b1;
    end else begin
      acc <= acc | acc_set;
      hit_valid <= 1'b0;
    end
  assign Red = rgb_q.r;
  assign Green = rgb_q.g;
  assign Blue = rgb_q.b;
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed checks of colour priority, rotation, shadowing and hit reporting.
module tb_layer_compositor;
  localparam int NT = 2;
  localparam int NB = 3;
  localparam int CW = 10;
  localparam int TW = 8;
  logic CLK = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_start = 1'b0;
  logic blank = 1'b0;
  logic maze = 1'b0;
  logic title = 1'b0;
  logic [CW-1:0] DrawX = '0;
  logic [CW-1:0] DrawY = '0;
  logic [CW-1:0] tank_size = '0;
  logic [NT*CW-1:0] tank_x = '0;
  logic [NT*CW-1:0] tank_y = '0;
  logic [NT*TW-1:0] tank_sin = '0;
  logic [NT*TW-1:0] tank_cos = '0;
  logic [NT-1:0] tank_dead = '0;
  logic [NB*CW-1:0] bul_x = '0;
  logic [NB*CW-1:0] bul_y = '0;
  logic [NB*CW-1:0] bul_s = '0;
  logic [NB-1:0] bul_active = '0;
  logic [7:0] Red, Green, Blue;
  logic [NT*NB-1:0] hit_flags;
  logic hit_valid;
  int checks = 0;
  int failures = 0;
  always #5 CLK = ~CLK;
  layer_compositor #(.NUM_TANKS(NT), .NUM_BULLETS(NB), .COORD_W(CW), .TRIG_W(TW), .HEAD_HALF(6)) dut (
    .CLK(CLK),
    .Reset_n(Reset_n),
    .frame_start(frame_start),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .blank(blank),
    .maze(maze),
    .title(title),
    .tank_x(tank_x),
    .tank_y(tank_y),
    .tank_size(tank_size),
    .tank_sin(tank_sin),
    .tank_cos(tank_cos),
    .tank_dead(tank_dead),
    .bul_x(bul_x),
    .bul_y(bul_y),
    .bul_s(bul_s),
    .bul_active(bul_active),
    .Red(Red),
    .Green(Green),
    .Blue(Blue),
    .hit_flags(hit_flags),
    .hit_valid(hit_valid)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic pix(input string tag, input logic [CW-1:0] x, input logic [CW-1:0] y,
                     input logic b, input logic m, input logic t, input logic [23:0] exp);
    DrawX = x;
    DrawY = y;
    blank = b;
    maze = m;
    title = t;
    repeat (3) @(posedge CLK);
    #1 chk(tag, {Red, Green, Blue}, exp);
  endtask
  task automatic fs(input string tag, input logic [NT*NB-1:0] exp);
    blank = 1'b0;
    maze = 1'b0;
    title = 1'b0;
    repeat (4) @(posedge CLK);
    #1 frame_start = 1'b1;
    @(posedge CLK);
    #1 frame_start = 1'b0;
    chk({tag, "_valid"}, hit_valid, 1);
    chk({tag, "_flags"}, hit_flags, exp);
    @(posedge CLK);
    #1 chk({tag, "_pulse"}, hit_valid, 0);
  endtask
  initial begin
    DrawX = 10'd100;
    DrawY = 10'd100;
    blank = 1'b1;
    repeat (3) @(posedge CLK);
    #1 chk("reset_rgb", {Red, Green, Blue}, 24'h000000);
    chk("reset_flags", hit_flags, 0);
    chk("reset_valid", hit_valid, 0);
    Reset_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1 chk("post_reset_c2", {Red, Green, Blue}, 24'h000000);
    @(posedge CLK);
    #1 chk("post_reset_c3", {Red, Green, Blue}, 24'h555555);
    tank_x = {10'd500, 10'd320};
    tank_y = {10'd240, 10'd240};
    tank_size = 10'd8;
    tank_cos = {8'd0, 8'd64};
    tank_sin = {8'd0, 8'd0};
    tank_dead = 2'b10;
    fs("fs_init", 6'b000000);
    pix("head_0deg", 10'd325, 10'd240, 1'b1, 1'b0, 1'b0, 24'h00FFFF);
    pix("body_0deg", 10'd315, 10'd240, 1'b1, 1'b0, 1'b0, 24'hFFBB00);
    pix("outside_0deg", 10'd329, 10'd240, 1'b1, 1'b0, 1'b0, 24'h555555);
    pix("dead_tank", 10'd500, 10'd240, 1'b1, 1'b0, 1'b0, 24'h555555);
    tank_cos = {8'd0, 8'd0};
    tank_sin = {8'd0, 8'd64};
    fs("fs_rot", 6'b000000);
    pix("head_90deg", 10'd320, 10'd245, 1'b1, 1'b0, 1'b0, 24'h00FFFF);
    pix("body_90deg_rear", 10'd320, 10'd235, 1'b1, 1'b0, 1'b0, 24'hFFBB00);
    pix("body_90deg_side", 10'd327, 10'd240, 1'b1, 1'b0, 1'b0, 24'hFFBB00);
    tank_cos = {8'd0, 8'd64};
    tank_sin = {8'd0, 8'd0};
    fs("fs_unrot", 6'b000000);
    tank_x = {10'd500, 10'd400};
    pix("shadow_hold", 10'd325, 10'd240, 1'b1, 1'b0, 1'b0, 24'h00FFFF);
    fs("fs_move", 6'b000000);
    pix("shadow_moved", 10'd325, 10'd240, 1'b1, 1'b0, 1'b0, 24'h555555);
    tank_x = {10'd500, 10'd320};
    bul_x = {10'd0, 10'd322, 10'd0};
    bul_y = {10'd0, 10'd240, 10'd0};
    bul_s = {10'd0, 10'd2, 10'd0};
    bul_active = 3'b010;
    fs("fs_bul_latch", 6'b000000);
    pix("bullet_over_tank", 10'd322, 10'd240, 1'b1, 1'b0, 1'b0, 24'h000000);
    fs("fs_hit", 6'b000010);
    pix("tank_no_bullet", 10'd315, 10'd240, 1'b1, 1'b0, 1'b0, 24'hFFBB00);
    fs("fs_nohit", 6'b000000);
    pix("title_over_tank", 10'd315, 10'd240, 1'b1, 1'b0, 1'b1, 24'hFFFFFF);
    pix("maze_over_tank", 10'd315, 10'd240, 1'b1, 1'b1, 1'b0, 24'h000000);
    pix("maze_over_bullet", 10'd322, 10'd240, 1'b1, 1'b1, 1'b0, 24'h000000);
    fs("fs_maze_hit", 6'b000010);
    pix("blank_overlap", 10'd322, 10'd240, 1'b0, 1'b0, 1'b0, 24'h000000);
    fs("fs_blank", 6'b000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
